multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the MIPS-subset datapath (addu subu sll jr jalr ori lui addiu slti lw lb sw sb beq bgez j jal).
//  Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and gates the datapath write strobes per state.
//  Shares one memory port between instruction fetch and data access through a req/ready handshake.
//  Counts retired instructions.
// PARAMETERS
//  CNT_W  32  width of the retired-instruction counter
// PORTS
//  clk        in   1      clock, all state changes on rising edge
//  reset_n    in   1      asynchronous active-low reset
//  OPCODE     in   6      IR[31:26], taken from the IR register
//  FUNC       in   6      IR[5:0]
//  MEM_READY  in   1      memory completes the current MEM_REQ this cycle
//  MEM_REQ    out  1      memory access request; held until MEM_READY
//  IRWE       out  1      IR load strobe
//  MDRWE      out  1      MDR load strobe
//  PCWE       out  1      PC update strobe; NPC selects the target via NPCOP
//  RFWE       out  1      register-file write strobe
//  DMWE       out  1      store qualifier for MEM_REQ
//  NPCOP      out  3      000 PC+4, 001 beq, 010 j/jal, 011 jr/jalr, 100 bgez
//  EXTOP      out  2      00 sign-extend, 01 zero-extend (ori, lui)
//  ALUBMUX    out  3      000 rt, 001 extended immediate
//  ALUOP      out  4      0000 add, 0001 sub, 0010 or, 0100 lui, 0101 sll, 0110 slt
//  RFA3MUX    out  3      000 rd, 001 rt, 010 $31
//  RFWDMUX    out  3      000 ALU, 001 MDR word, 010 PC+4, 011 MDR byte
//  DMOP       out  3      000 word, 001 byte
//  STATE      out  3      FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4
//  ILLEGAL    out  1      one-cycle pulse when DECODE finds an unsupported encoding
//  RETIRED    out  CNT_W  count of completed instructions
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - STATE=FETCH, RETIRED=0.
//   - Every strobe (MEM_REQ IRWE MDRWE PCWE RFWE DMWE ILLEGAL) is ANDed with reset_n, so all strobes read 0 during reset.
//   - A reset mid-access drops MEM_REQ immediately. After release, fetch restarts.
//  Select outputs (NPCOP EXTOP ALUBMUX ALUOP RFA3MUX RFWDMUX DMOP):
//   - Combinational from OPCODE/FUNC, using the encodings above.
//   - Valid from DECODE onward. Don't-care in FETCH.
//  FETCH:
//   - MEM_REQ=1, DMWE=0.
//   - Stay in FETCH while MEM_READY=0.
//   - When MEM_READY=1: IRWE=1, then go to DECODE.
//  DECODE:
//   - j: PCWE=1, retire, go to FETCH.
//   - jr: PCWE=1, retire, go to FETCH.
//   - jal, jalr: go to WB.
//   - Unsupported encoding: ILLEGAL=1, PCWE=1 with NPCOP=000 (skip), retire, go to FETCH.
//   - All other instructions: go to EXEC.
//  EXEC (ALU operands are settled):
//   - beq, bgez: PCWE=1 (NPC resolves the condition), retire, go to FETCH.
//   - Loads and stores: go to MEM.
//   - All others: go to WB.
//  MEM:
//   - MEM_REQ=1. DMWE=1 for sw/sb.
//   - Stay in MEM while MEM_READY=0.
//   - On MEM_READY, loads: MDRWE=1, go to WB.
//   - On MEM_READY, stores: PCWE=1, retire, go to FETCH.
//  WB:
//   - RFWE=1, PCWE=1, retire, go to FETCH.
//   - jalr does not write $31: its RFA3MUX stays 000 (rd).
//  Retire: RETIRED increments by 1 in the cycle PCWE=1. Wraps modulo 2^CNT_W.
//  Exactly one PCWE and at most one RFWE per instruction.
//  Latencies with zero-wait memory:
//   - j, jr: 2 cycles.
//   - beq, bgez, jal, jalr: 3 cycles.
//   - ALU ops, sw, sb: 4 cycles.
//   - lw, lb: 5 cycles.
//   - Each MEM_READY=0 cycle adds one cycle.
//  MEM_READY is ignored outside FETCH and MEM.
//  MEM_REQ never deasserts before MEM_READY is seen, except under reset.
// TESTING
//  1. Reset held, then released; MEM_READY=1 constant -> STATE=0, RETIRED=0, all strobes 0 during reset; first cycle after release MEM_REQ=1, IRWE=1.
//  2. addu (OPCODE=0, FUNC=0x21), zero-wait -> states 0,1,2,4; RFWE=1 and PCWE=1 only in WB; ALUOP=0000, RFA3MUX=000; RETIRED +1.
//  3. lw (0x23) with MEM_READY low for 3 cycles in MEM -> MEM_REQ held 4 cycles, MDRWE=1 only in the ready cycle; RFWDMUX=001, RFA3MUX=001; 8 cycles total.
//  4. sb (0x28) -> DMWE=1 with MEM_REQ in MEM, DMOP=001; RFWE never 1; 4 cycles.
//  5. j, beq, jal, jalr back to back -> 2/3/3/3 cycles; jal: RFA3MUX=010, RFWDMUX=010; jalr: RFA3MUX=000; NPCOP=010/001/010/011.
//  6. OPCODE=0x3F, then reset_n pulsed low during a stalled fetch -> ILLEGAL pulse, PCWE with NPCOP=000; after reset, MEM_REQ=0 immediately, STATE=0, RETIRED=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for a MIPS-subset datapath: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB, shares one memory port via req/ready, counts retirements.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       OPCODE,
  input  logic [5:0]       FUNC,
  input  logic             MEM_READY,
  output logic             MEM_REQ,
  output logic             IRWE,
  output logic             MDRWE,
  output logic             PCWE,
  output logic             RFWE,
  output logic             DMWE,
  output logic [2:0]       NPCOP,
  output logic [1:0]       EXTOP,
  output logic [2:0]       ALUBMUX,
  output logic [3:0]       ALUOP,
  output logic [2:0]       RFA3MUX,
  output logic [2:0]       RFWDMUX,
  output logic [2:0]       DMOP,
  output logic [2:0]       STATE,
  output logic             ILLEGAL,
  output logic [CNT_W-1:0] RETIRED
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    C_JUMP,
    C_LINK,
    C_BRANCH,
    C_ALU,
    C_LOAD,
    C_STORE,
    C_ILLEGAL
  } cls_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  cls_t             cls;

  logic mem_req, irwe, mdrwe, pcwe, rfwe, dmwe, illegal;

  // Instruction class and datapath selects; illegal encodings keep NPCOP=000 so PC just skips.
  always_comb begin
    cls     = C_ILLEGAL;
    NPCOP   = 3'b000;
    EXTOP   = 2'b00;
    ALUBMUX = 3'b000;
    ALUOP   = 4'b0000;
    RFA3MUX = 3'b000;
    RFWDMUX = 3'b000;
    DMOP    = 3'b000;
    case (OPCODE)
      6'h00: begin
        case (FUNC)
          6'h21: cls = C_ALU;
          6'h23: begin cls = C_ALU; ALUOP = 4'b0001; end
          6'h00: begin cls = C_ALU; ALUOP = 4'b0101; end
          6'h08: begin cls = C_JUMP; NPCOP = 3'b011; end
          6'h09: begin cls = C_LINK; NPCOP = 3'b011; RFWDMUX = 3'b010; end
          default: cls = C_ILLEGAL;
        endcase
      end
      6'h0D: begin
        cls = C_ALU; EXTOP = 2'b01; ALUBMUX = 3'b001; ALUOP = 4'b0010; RFA3MUX = 3'b001;
      end
      6'h0F: begin
        cls = C_ALU; EXTOP = 2'b01; ALUBMUX = 3'b001; ALUOP = 4'b0100; RFA3MUX = 3'b001;
      end
      6'h09: begin cls = C_ALU; ALUBMUX = 3'b001; RFA3MUX = 3'b001; end
      6'h0A: begin cls = C_ALU; ALUBMUX = 3'b001; ALUOP = 4'b0110; RFA3MUX = 3'b001; end
      6'h23: begin cls = C_LOAD; ALUBMUX = 3'b001; RFA3MUX = 3'b001; RFWDMUX = 3'b001; end
      6'h20: begin
        cls = C_LOAD; ALUBMUX = 3'b001; RFA3MUX = 3'b001; RFWDMUX = 3'b011; DMOP = 3'b001;
      end
      6'h2B: begin cls = C_STORE; ALUBMUX = 3'b001; end
      6'h28: begin cls = C_STORE; ALUBMUX = 3'b001; DMOP = 3'b001; end
      6'h04: begin cls = C_BRANCH; NPCOP = 3'b001; ALUOP = 4'b0001; end
      6'h01: begin cls = C_BRANCH; NPCOP = 3'b100; end
      6'h02: begin cls = C_JUMP; NPCOP = 3'b010; end
      6'h03: begin cls = C_LINK; NPCOP = 3'b010; RFA3MUX = 3'b010; RFWDMUX = 3'b010; end
      default: cls = C_ILLEGAL;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    irwe    = 1'b0;
    mdrwe   = 1'b0;
    pcwe    = 1'b0;
    rfwe    = 1'b0;
    dmwe    = 1'b0;
    illegal = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (MEM_READY) begin
          irwe    = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (cls)
          C_JUMP:    begin pcwe = 1'b1; state_d = S_FETCH; end
          C_ILLEGAL: begin illegal = 1'b1; pcwe = 1'b1; state_d = S_FETCH; end
          C_LINK:    state_d = S_WB;
          default:   state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls)
          C_BRANCH:        begin pcwe = 1'b1; state_d = S_FETCH; end
          C_LOAD, C_STORE: state_d = S_MEM;
          default:         state_d = S_WB;
        endcase
      end
      S_MEM: begin
        // Request stays up until the memory acknowledges.
        mem_req = 1'b1;
        dmwe    = (cls == C_STORE);
        if (MEM_READY) begin
          if (cls == C_STORE) begin
            pcwe    = 1'b1;
            state_d = S_FETCH;
          end else begin
            mdrwe   = 1'b1;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rfwe    = 1'b1;
        pcwe    = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    retired_d = retired_q + CNT_W'(pcwe);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Strobes are forced low combinationally while reset is asserted.
  assign MEM_REQ = mem_req & reset_n;
  assign IRWE    = irwe    & reset_n;
  assign MDRWE   = mdrwe   & reset_n;
  assign PCWE    = pcwe    & reset_n;
  assign RFWE    = rfwe    & reset_n;
  assign DMWE    = dmwe    & reset_n;
  assign ILLEGAL = illegal & reset_n;
  assign STATE   = state_q;
  assign RETIRED = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios then random instruction/stall mixes,
// each cycle compared against a phase-sequence model built from the instruction class.
module tb_multicycle_ctrl;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [5:0]       OPCODE = '0;
  logic [5:0]       FUNC = '0;
  logic             MEM_READY = 1'b0;
  logic             MEM_REQ, IRWE, MDRWE, PCWE, RFWE, DMWE, ILLEGAL;
  logic [2:0]       NPCOP, ALUBMUX, RFA3MUX, RFWDMUX, DMOP, STATE;
  logic [1:0]       EXTOP;
  logic [3:0]       ALUOP;
  logic [CNT_W-1:0] RETIRED;
  logic [6:0]       strb;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .OPCODE(OPCODE), .FUNC(FUNC), .MEM_READY(MEM_READY),
    .MEM_REQ(MEM_REQ), .IRWE(IRWE), .MDRWE(MDRWE), .PCWE(PCWE), .RFWE(RFWE), .DMWE(DMWE),
    .NPCOP(NPCOP), .EXTOP(EXTOP), .ALUBMUX(ALUBMUX), .ALUOP(ALUOP), .RFA3MUX(RFA3MUX),
    .RFWDMUX(RFWDMUX), .DMOP(DMOP), .STATE(STATE), .ILLEGAL(ILLEGAL), .RETIRED(RETIRED)
  );

  always #5 clk = ~clk;

  // Strobe vector order: MEM_REQ IRWE MDRWE PCWE RFWE DMWE ILLEGAL
  assign strb = {MEM_REQ, IRWE, MDRWE, PCWE, RFWE, DMWE, ILLEGAL};

  localparam int C_JUMP = 0, C_LINK = 1, C_BR = 2, C_ALU = 3, C_LOAD = 4, C_STORE = 5, C_ILL = 6;

  typedef struct packed {
    logic [2:0] npc;
    logic [1:0] ext;
    logic [2:0] bm;
    logic [3:0] alu;
    logic [2:0] a3;
    logic [2:0] wd;
    logic [2:0] dm;
  } sel_t;

  int               n_asserts = 0;
  int               n_fails = 0;
  logic [CNT_W-1:0] rc = '0;

  logic [11:0] enc_tab [0:17] = '{
    {6'h00, 6'h21}, {6'h00, 6'h23}, {6'h00, 6'h00}, {6'h00, 6'h08}, {6'h00, 6'h09},
    {6'h0D, 6'h00}, {6'h0F, 6'h00}, {6'h09, 6'h00}, {6'h0A, 6'h00}, {6'h23, 6'h00},
    {6'h20, 6'h00}, {6'h2B, 6'h00}, {6'h28, 6'h00}, {6'h04, 6'h00}, {6'h01, 6'h00},
    {6'h02, 6'h00}, {6'h3F, 6'h00}, {6'h00, 6'h2A}
  };

  // Instruction table: class and the select encodings each mnemonic needs.
  function automatic int lookup(input logic [5:0] op, input logic [5:0] fn, output sel_t s);
    int c;
    s = '0;
    c = C_ILL;
    if (op == 6'h00) begin
      if (fn == 6'h21) c = C_ALU;
      if (fn == 6'h23) begin c = C_ALU; s.alu = 4'b0001; end
      if (fn == 6'h00) begin c = C_ALU; s.alu = 4'b0101; end
      if (fn == 6'h08) begin c = C_JUMP; s.npc = 3'b011; end
      if (fn == 6'h09) begin c = C_LINK; s.npc = 3'b011; s.a3 = 3'b000; s.wd = 3'b010; end
    end
    if (op == 6'h0D) begin c = C_ALU; s.ext = 2'b01; s.bm = 3'b001; s.alu = 4'b0010; s.a3 = 3'b001; end
    if (op == 6'h0F) begin c = C_ALU; s.ext = 2'b01; s.bm = 3'b001; s.alu = 4'b0100; s.a3 = 3'b001; end
    if (op == 6'h09) begin c = C_ALU; s.bm = 3'b001; s.alu = 4'b0000; s.a3 = 3'b001; end
    if (op == 6'h0A) begin c = C_ALU; s.bm = 3'b001; s.alu = 4'b0110; s.a3 = 3'b001; end
    if (op == 6'h23) begin c = C_LOAD; s.bm = 3'b001; s.a3 = 3'b001; s.wd = 3'b001; s.dm = 3'b000; end
    if (op == 6'h20) begin c = C_LOAD; s.bm = 3'b001; s.a3 = 3'b001; s.wd = 3'b011; s.dm = 3'b001; end
    if (op == 6'h2B) begin c = C_STORE; s.bm = 3'b001; s.dm = 3'b000; end
    if (op == 6'h28) begin c = C_STORE; s.bm = 3'b001; s.dm = 3'b001; end
    if (op == 6'h04) begin c = C_BR; s.npc = 3'b001; end
    if (op == 6'h01) begin c = C_BR; s.npc = 3'b100; end
    if (op == 6'h02) begin c = C_JUMP; s.npc = 3'b010; end
    if (op == 6'h03) begin c = C_LINK; s.npc = 3'b010; s.a3 = 3'b010; s.wd = 3'b010; end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive MEM_READY, check state/strobes/counter, step to next negedge.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [6:0] es, input logic rdy);
    MEM_READY = rdy;
    #1;
    chk({tag, "/state"}, CNT_W'(STATE), CNT_W'(st));
    chk({tag, "/strobes"}, CNT_W'(strb), CNT_W'(es));
    chk({tag, "/retired"}, RETIRED, rc);
    if (es[3]) rc = rc + 1'b1;
    @(negedge clk);
  endtask

  task automatic run_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                           input int fst, input int mst);
    int   c;
    sel_t s;
    logic last, st;
    c = lookup(op, fn, s);
    OPCODE = op;
    FUNC = fn;
    for (int i = 0; i <= fst; i++) begin
      last = (i == fst);
      cyc({nm, "/F"}, 3'd0, {1'b1, last, 5'b0}, last);
    end
    chk({nm, "/NPCOP"}, CNT_W'(NPCOP), CNT_W'(s.npc));
    if (c == C_ALU || c == C_LOAD || c == C_STORE) begin
      chk({nm, "/ALUOP"}, CNT_W'(ALUOP), CNT_W'(s.alu));
      chk({nm, "/ALUBMUX"}, CNT_W'(ALUBMUX), CNT_W'(s.bm));
      if (s.bm == 3'b001) chk({nm, "/EXTOP"}, CNT_W'(EXTOP), CNT_W'(s.ext));
    end
    if (c == C_ALU || c == C_LOAD || c == C_LINK) begin
      chk({nm, "/RFA3MUX"}, CNT_W'(RFA3MUX), CNT_W'(s.a3));
      chk({nm, "/RFWDMUX"}, CNT_W'(RFWDMUX), CNT_W'(s.wd));
    end
    if (c == C_LOAD || c == C_STORE) chk({nm, "/DMOP"}, CNT_W'(DMOP), CNT_W'(s.dm));
    if (c == C_JUMP) begin
      cyc({nm, "/D"}, 3'd1, 7'b0001000, 1'($urandom_range(0, 1)));
    end else if (c == C_ILL) begin
      cyc({nm, "/D"}, 3'd1, 7'b0001001, 1'($urandom_range(0, 1)));
    end else if (c == C_LINK) begin
      cyc({nm, "/D"}, 3'd1, 7'b0000000, 1'($urandom_range(0, 1)));
      cyc({nm, "/W"}, 3'd4, 7'b0001100, 1'($urandom_range(0, 1)));
    end else begin
      cyc({nm, "/D"}, 3'd1, 7'b0000000, 1'($urandom_range(0, 1)));
      if (c == C_BR) begin
        cyc({nm, "/E"}, 3'd2, 7'b0001000, 1'($urandom_range(0, 1)));
      end else if (c == C_ALU) begin
        cyc({nm, "/E"}, 3'd2, 7'b0000000, 1'($urandom_range(0, 1)));
        cyc({nm, "/W"}, 3'd4, 7'b0001100, 1'($urandom_range(0, 1)));
      end else begin
        cyc({nm, "/E"}, 3'd2, 7'b0000000, 1'($urandom_range(0, 1)));
        st = (c == C_STORE);
        for (int i = 0; i <= mst; i++) begin
          last = (i == mst);
          cyc({nm, "/M"}, 3'd3, {1'b1, 1'b0, last & ~st, last & st, 1'b0, st, 1'b0}, last);
        end
        if (c == C_LOAD) cyc({nm, "/W"}, 3'd4, 7'b0001100, 1'($urandom_range(0, 1)));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] op, fn;
    int         k;

    // Reset held with MEM_READY high: everything quiet
    reset_n = 1'b0;
    MEM_READY = 1'b1;
    OPCODE = 6'h23;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rst/state", CNT_W'(STATE), '0);
      chk("rst/strobes", CNT_W'(strb), '0);
      chk("rst/retired", RETIRED, '0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    rc = '0;

    run_instr("addu", 6'h00, 6'h21, 0, 0);
    run_instr("lw_stall", 6'h23, 6'h00, 0, 3);
    run_instr("sb", 6'h28, 6'h00, 0, 0);
    run_instr("j", 6'h02, 6'h00, 0, 0);
    run_instr("beq", 6'h04, 6'h00, 0, 0);
    run_instr("jal", 6'h03, 6'h00, 0, 0);
    run_instr("jalr", 6'h00, 6'h09, 0, 0);
    run_instr("ill", 6'h3F, 6'h00, 0, 0);

    // Reset arriving in the middle of a stalled fetch
    OPCODE = 6'h3F;
    cyc("stallf", 3'd0, 7'b1000000, 1'b0);
    MEM_READY = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    chk("midrst/strobes", CNT_W'(strb), '0);
    chk("midrst/state", CNT_W'(STATE), '0);
    chk("midrst/retired", RETIRED, '0);
    @(negedge clk);
    #1;
    chk("midrst/hold_req", CNT_W'(MEM_REQ), '0);
    @(negedge clk);
    reset_n = 1'b1;
    rc = '0;
    run_instr("post_rst", 6'h2B, 6'h00, 1, 1);

    // Random instruction mix with random fetch/memory wait states
    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 17);
      op = enc_tab[k][11:6];
      fn = enc_tab[k][5:0];
      if (op != 6'h00) fn = 6'($urandom);
      run_instr("rnd", op, fn, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    #1;
    chk("end/state", CNT_W'(STATE), '0);
    chk("end/retired", RETIRED, rc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
